// File: rtl/sum_display_driver.sv
// Captures a 5-bit adder sum, converts it to BCD with a sequential double-dabble engine,
// and multiplexes the two digits onto an active-low seven-segment display. Option: SUM_DISPLAY_BLANK_EN.
module sum_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sum_in,
  input  logic       sum_valid,
  output logic       ready,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       carry_led
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_nx;
  logic [12:0] sr, sr_nx, sr_step;
  logic [3:0]  adj_tens, adj_ones;
  logic [2:0]  step, step_nx;
  logic        cap_carry, cap_carry_nx;
  logic        done;
  logic [3:0]  tens, ones;
  logic [CW-1:0] cnt;
  logic        digit_sel, wrap;
  logic [3:0]  digit;
  logic [6:0]  seg_nx;
  logic [1:0]  an_nx;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
  endfunction

  // One shift-add-3 step: correct nibbles >= 5 before the shift so they carry into the next digit.
  always_comb begin
    adj_tens = sr[12:9];
    adj_ones = sr[8:5];
    if (adj_tens >= 4'd5) adj_tens = adj_tens + 4'd3;
    if (adj_ones >= 4'd5) adj_ones = adj_ones + 4'd3;
    sr_step = {adj_tens, adj_ones, sr[4:0]} << 1;
  end

  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    step_nx      = step;
    cap_carry_nx = cap_carry;
    done         = 1'b0;
    ready        = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (sum_valid) begin
          sr_nx        = {8'd0, sum_in};
          step_nx      = 3'd0;
          cap_carry_nx = sum_in[4];
          state_nx     = CONV;
        end
      end
      CONV: begin
        sr_nx   = sr_step;
        step_nx = step + 3'd1;
        if (step == 3'd4) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      step      <= '0;
      cap_carry <= 1'b0;
      tens      <= '0;
      ones      <= '0;
      carry_led <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      step      <= step_nx;
      cap_carry <= cap_carry_nx;
      if (done) begin
        tens      <= sr_step[12:9];
        ones      <= sr_step[8:5];
        carry_led <= cap_carry;
      end
    end
  end

  // Refresh path runs freely, independent of the conversion FSM.
  assign wrap = (cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      digit_sel <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) digit_sel <= ~digit_sel;
    end
  end

  always_comb begin
    digit  = digit_sel ? tens : ones;
    an_nx  = digit_sel ? 2'b01 : 2'b10;
    seg_nx = pattern(digit);
`ifdef SUM_DISPLAY_BLANK_EN
    if (digit_sel && (tens == 4'd0)) begin
      an_nx  = 2'b11;
      seg_nx = 7'b1111111;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 2'b11;
      seg <= 7'b1111111;
    end else begin
      an  <= an_nx;
      seg <= seg_nx;
    end
  end

endmodule

// File: tb/tb_sum_display_driver.sv
// Bench for sum_display_driver: directed and random sums checked against a decimal/slot-timing model.
module tb_sum_display_driver;
  localparam int DIV = 4;
`ifdef SUM_DISPLAY_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sum_in = '0;
  logic       sum_valid = 1'b0;
  logic       ready, carry_led;
  logic [6:0] seg;
  logic [1:0] an;

  int total = 0;
  int bad = 0;
  int ec;
  int m_tens = 0, m_ones = 0;
  logic m_carry = 1'b0;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  sum_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .sum_valid(sum_valid),
    .ready(ready), .seg(seg), .an(an), .carry_led(carry_led)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release; the display slot follows from it directly.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_model(input int v);
    m_tens  = v / 10;
    m_ones  = v % 10;
    m_carry = v[4];
  endtask

  task automatic chk_disp(input int n);
    int slot;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      slot = ((ec - 1) / DIV) % 2;
      if (slot == 0) begin
        chk("an_ones", an, 2'b10);
        chk("seg_ones", seg, pat[m_ones]);
      end else if (BLANK && m_tens == 0) begin
        chk("an_blank", an, 2'b11);
        chk("seg_blank", seg, 7'b1111111);
      end else begin
        chk("an_tens", an, 2'b01);
        chk("seg_tens", seg, pat[m_tens]);
      end
      chk("carry_led", carry_led, m_carry);
      chk("idle_ready", ready, 1'b1);
    end
  endtask

  task automatic convert(input logic [4:0] v);
    @(negedge clk);
    chk("pre_ready", ready, 1'b1);
    sum_in = v;
    sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("busy_ready", ready, 1'b0);
      @(negedge clk);
    end
    chk("done_ready", ready, 1'b1);
    chk("done_carry", carry_led, v[4]);
    set_model(int'(v));
  endtask

  initial begin
    int k;
    logic [4:0] r;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", an, 2'b11);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_ready", ready, 1'b1);
    chk("rst_carry", carry_led, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_an", an, 2'b10);
    chk("first_seg", seg, 7'b1000000);
    chk_disp(9);

    // Directed values, including carry and the out-of-range 31
    convert(5'd19); chk_disp(10);
    convert(5'd30); chk_disp(10);
    convert(5'd7);  chk_disp(10);
    convert(5'd0);  chk_disp(9);
    convert(5'd31); chk_disp(10);

    // Busy drop: a second strobe during conversion must be ignored
    @(negedge clk);
    sum_in = 5'd12; sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    @(negedge clk);
    sum_in = 5'd3; sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    k = 0;
    while (ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("busy_wait_bound", k < 20, 1'b1);
    set_model(12);
    @(negedge clk);
    chk_disp(12);

    // Random sums
    for (int i = 0; i < 10; i++) begin
      r = 5'($urandom_range(0, 31));
      convert(r);
      chk_disp(3 + int'($urandom_range(0, 7)));
    end

    // Reset mid-conversion of 25: partial result discarded, display cleared
    @(negedge clk);
    sum_in = 5'd25; sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_an", an, 2'b11);
    chk("mid_rst_seg", seg, 7'b1111111);
    chk("mid_rst_carry", carry_led, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    set_model(0);
    chk_disp(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
